// File: rtl/uart_tx_fifo_ctrl.sv
// Read-side sequencer: drains the async byte FIFO into the UART transmitter
// over a start/busy handshake, with a flush (discard) mode and a sent-byte count.
module uart_tx_fifo_ctrl #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   flush,
  input  logic                   fifo_empty,
  input  logic [DATA_WIDTH-1:0]  fifo_data,
  output logic                   fifo_rd_en,
  input  logic                   tx_busy,
  output logic                   tx_start,
  output logic [DATA_WIDTH-1:0]  tx_data,
  output logic [COUNT_WIDTH-1:0] tx_count,
  output logic                   active
);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    FETCH,
    WAIT_ACK,
    WAIT_DONE
  } state_e;

  state_e                 state_q, state_d;
  logic                   discard_q, discard_d;
  logic                   fifo_rd_en_q, fifo_rd_en_d;
  logic                   tx_start_q, tx_start_d;
  logic [DATA_WIDTH-1:0]  tx_data_q, tx_data_d;
  logic [COUNT_WIDTH-1:0] tx_count_q, tx_count_d;
  logic                   active_q, active_d;

  always_comb begin
    state_d      = state_q;
    discard_d    = discard_q;
    fifo_rd_en_d = 1'b0;
    tx_start_d   = tx_start_q;
    tx_data_d    = tx_data_q;
    tx_count_d   = tx_count_q;
    case (state_q)
      IDLE: begin
        // The read strobe is raised on entry so it is high exactly while in READ.
        if (!fifo_empty && flush) begin
          discard_d    = 1'b1;
          fifo_rd_en_d = 1'b1;
          state_d      = READ;
        end else if (!fifo_empty && enable && !tx_busy) begin
          discard_d    = 1'b0;
          fifo_rd_en_d = 1'b1;
          state_d      = READ;
        end
      end
      READ: state_d = FETCH;
      FETCH: begin
        if (discard_q) begin
          state_d = IDLE;
        end else begin
          tx_data_d  = fifo_data;
          tx_start_d = 1'b1;
          tx_count_d = tx_count_q + 1'b1;
          state_d    = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (tx_busy) begin
          tx_start_d = 1'b0;
          state_d    = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    active_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      discard_q    <= 1'b0;
      fifo_rd_en_q <= 1'b0;
      tx_start_q   <= 1'b0;
      tx_data_q    <= '0;
      tx_count_q   <= '0;
      active_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      discard_q    <= discard_d;
      fifo_rd_en_q <= fifo_rd_en_d;
      tx_start_q   <= tx_start_d;
      tx_data_q    <= tx_data_d;
      tx_count_q   <= tx_count_d;
      active_q     <= active_d;
    end
  end

  assign fifo_rd_en = fifo_rd_en_q;
  assign tx_start   = tx_start_q;
  assign tx_data    = tx_data_q;
  assign tx_count   = tx_count_q;
  assign active     = active_q;

endmodule

// File: tb/tb_uart_tx_fifo_ctrl.sv
// Directed bench for uart_tx_fifo_ctrl with a registered-flag FIFO model and a
// start/busy UART model; a 4-bit-count instance exercises counter wrap cheaply.
`timescale 1ns/1ps
module tb_uart_tx_fifo_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        flush = 1'b0;
  logic        fifo_empty = 1'b1;
  logic        tx_busy = 1'b0;
  logic [7:0]  fifo_data = 8'h00;
  logic        fifo_rd_en, tx_start, active;
  logic [7:0]  tx_data;
  logic [15:0] tx_count;
  logic        n_rd_en, n_start, n_active;
  logic [7:0]  n_data;
  logic [3:0]  n_count;

  int vectors = 0;
  int errors  = 0;

  logic [7:0] fifo_q[$];
  logic [7:0] sent_q[$];
  int         rd_cycles[$];
  int rd_pulses = 0, underflow = 0, start_seen = 0, stab_err = 0, cyc = 0;
  int busy_len = 4, ack_delay = 0, busy_cnt = 0, ack_cnt = 0;
  logic       prev_start = 1'b0;
  logic [7:0] prev_data = 8'h00;

  uart_tx_fifo_ctrl #(.DATA_WIDTH(8), .COUNT_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .enable(enable), .flush(flush),
    .fifo_empty(fifo_empty), .fifo_data(fifo_data), .fifo_rd_en(fifo_rd_en),
    .tx_busy(tx_busy), .tx_start(tx_start), .tx_data(tx_data),
    .tx_count(tx_count), .active(active)
  );

  uart_tx_fifo_ctrl #(.DATA_WIDTH(8), .COUNT_WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .enable(enable), .flush(flush),
    .fifo_empty(fifo_empty), .fifo_data(fifo_data), .fifo_rd_en(n_rd_en),
    .tx_busy(tx_busy), .tx_start(n_start), .tx_data(n_data),
    .tx_count(n_count), .active(n_active)
  );

  always #5 clk = ~clk;

  // FIFO with registered read data and registered empty flag; UART model with
  // configurable acknowledge delay and busy length.
  always @(posedge clk) begin
    cyc++;
    if (fifo_rd_en) begin
      rd_pulses++;
      rd_cycles.push_back(cyc);
      if (fifo_q.size() == 0) underflow++;
      else fifo_data <= fifo_q.pop_front();
    end
    fifo_empty <= (fifo_q.size() == 0);
    if (tx_start) start_seen++;
    if (tx_start && prev_start && (tx_data !== prev_data)) stab_err++;
    prev_start = tx_start;
    prev_data  = tx_data;
    if (busy_cnt != 0) begin
      busy_cnt--;
      if (busy_cnt == 0) tx_busy <= 1'b0;
    end else if (tx_start && !tx_busy) begin
      if (ack_cnt < ack_delay) ack_cnt++;
      else begin
        sent_q.push_back(tx_data);
        tx_busy  <= 1'b1;
        busy_cnt = busy_len;
        ack_cnt  = 0;
      end
    end else begin
      ack_cnt = 0;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    sent_q.delete();
    rd_cycles.delete();
    rd_pulses = 0; underflow = 0; start_seen = 0; stab_err = 0;
  endtask

  task automatic wait_idle(input int max_cycles, output bit ok);
    ok = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < max_cycles; i++) begin
      if (!active && !tx_busy && (fifo_empty || (!enable && !flush))) begin
        ok = 1'b1;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    vectors++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %b expected 0", fifo_rd_en); end
    vectors++; if (tx_start !== 1'b0) begin errors++; $display("FAIL reset_tx_start: got %b expected 0", tx_start); end
    vectors++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h expected 00", tx_data); end
    vectors++; if (tx_count !== 16'h0000) begin errors++; $display("FAIL reset_tx_count: got %h expected 0000", tx_count); end
    vectors++; if (active !== 1'b0) begin errors++; $display("FAIL reset_active: got %b expected 0", active); end
    reset = 1'b0;
  endtask

  task automatic test_single();
    bit ok;
    bit held;
    do_reset();
    enable = 1'b1; ack_delay = 3; busy_len = 4;
    fifo_q.push_back(8'hA5);
    @(negedge clk);
    vectors++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL single_rd_early: got %b expected 0", fifo_rd_en); end
    @(negedge clk);
    vectors++; if (fifo_rd_en !== 1'b1 || active !== 1'b1) begin errors++; $display("FAIL single_rd_pulse: got rd=%b act=%b expected 1 1", fifo_rd_en, active); end
    @(negedge clk);
    vectors++; if (fifo_rd_en !== 1'b0 || tx_start !== 1'b0) begin errors++; $display("FAIL single_fetch: got rd=%b start=%b expected 0 0", fifo_rd_en, tx_start); end
    @(negedge clk);
    vectors++; if (tx_start !== 1'b1 || tx_data !== 8'hA5) begin errors++; $display("FAIL single_start: got start=%b data=%h expected 1 a5", tx_start, tx_data); end
    vectors++; if (tx_count !== 16'd1) begin errors++; $display("FAIL single_count_edge: got %0d expected 1", tx_count); end
    held = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (tx_start !== 1'b1) held = 1'b0;
    end
    vectors++; if (!held) begin errors++; $display("FAIL single_hold: got start dropped expected held until busy"); end
    @(negedge clk);
    vectors++; if (tx_start !== 1'b0 || tx_busy !== 1'b1) begin errors++; $display("FAIL single_release: got start=%b busy=%b expected 0 1", tx_start, tx_busy); end
    wait_idle(100, ok);
    vectors++; if (!ok) begin errors++; $display("FAIL single_timeout: got busy expected idle"); end
    vectors++; if (sent_q.size() != 1 || sent_q[0] !== 8'hA5) begin errors++; $display("FAIL single_sent: got %0d bytes expected 1 byte a5", sent_q.size()); end
    vectors++; if (rd_pulses != 1) begin errors++; $display("FAIL single_rd_count: got %0d expected 1", rd_pulses); end
    vectors++; if (stab_err != 0) begin errors++; $display("FAIL single_data_stable: got %0d changes expected 0", stab_err); end
  endtask

  task automatic test_burst();
    bit ok;
    logic [7:0] exp [3];
    exp[0] = 8'h01; exp[1] = 8'h02; exp[2] = 8'h03;
    do_reset();
    enable = 1'b1; ack_delay = 0; busy_len = 20;
    @(negedge clk);
    for (int i = 0; i < 3; i++) fifo_q.push_back(exp[i]);
    wait_idle(500, ok);
    vectors++; if (!ok) begin errors++; $display("FAIL burst_timeout: got busy expected idle"); end
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (sent_q.size() <= i || sent_q[i] !== exp[i]) begin
        errors++; $display("FAIL burst_byte%0d: got %h expected %h", i, (sent_q.size() > i) ? sent_q[i] : 8'hxx, exp[i]);
      end
    end
    vectors++; if (rd_pulses != 3) begin errors++; $display("FAIL burst_rd_count: got %0d expected 3", rd_pulses); end
    vectors++; if (tx_count !== 16'd3) begin errors++; $display("FAIL burst_count: got %0d expected 3", tx_count); end
    vectors++; if (fifo_empty !== 1'b1 || underflow != 0) begin errors++; $display("FAIL burst_empty: got empty=%b underflow=%0d expected 1 0", fifo_empty, underflow); end
  endtask

  task automatic test_flush();
    bit ok;
    bit spaced;
    do_reset();
    enable = 1'b0; flush = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) fifo_q.push_back(8'h10 + 8'(i));
    wait_idle(200, ok);
    flush = 1'b0;
    vectors++; if (!ok) begin errors++; $display("FAIL flush_timeout: got busy expected idle"); end
    vectors++; if (rd_pulses != 4) begin errors++; $display("FAIL flush_rd_count: got %0d expected 4", rd_pulses); end
    spaced = (rd_cycles.size() == 4);
    for (int i = 1; i < rd_cycles.size(); i++) if (rd_cycles[i] - rd_cycles[i-1] != 3) spaced = 1'b0;
    vectors++; if (!spaced) begin errors++; $display("FAIL flush_spacing: got irregular read spacing expected 3 cycles"); end
    vectors++; if (start_seen != 0) begin errors++; $display("FAIL flush_no_start: got %0d start cycles expected 0", start_seen); end
    vectors++; if (tx_count !== 16'd0) begin errors++; $display("FAIL flush_count: got %0d expected 0", tx_count); end
    vectors++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL flush_empty: got %b expected 1", fifo_empty); end
  endtask

  task automatic test_enable_drop();
    bit ok;
    int n;
    do_reset();
    enable = 1'b1; ack_delay = 0; busy_len = 20;
    @(negedge clk);
    fifo_q.push_back(8'h31); fifo_q.push_back(8'h32); fifo_q.push_back(8'h33);
    n = 0;
    while (tx_busy !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    vectors++; if (tx_busy !== 1'b1) begin errors++; $display("FAIL drop_busy_wait: got busy=%b expected 1", tx_busy); end
    enable = 1'b0;
    wait_idle(100, ok);
    repeat (10) @(negedge clk);
    vectors++; if (!ok) begin errors++; $display("FAIL drop_timeout: got busy expected idle"); end
    vectors++; if (sent_q.size() != 1 || sent_q[0] !== 8'h31) begin errors++; $display("FAIL drop_sent: got %0d bytes expected 1 byte 31", sent_q.size()); end
    vectors++; if (rd_pulses != 1) begin errors++; $display("FAIL drop_rd_count: got %0d expected 1", rd_pulses); end
    vectors++; if (fifo_q.size() != 2) begin errors++; $display("FAIL drop_retained: got %0d expected 2", fifo_q.size()); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int n;
    do_reset();
    ack_delay = 100; busy_len = 3; enable = 1'b1;
    n = 0;
    while (tx_start !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    vectors++; if (tx_start !== 1'b1 || tx_data !== 8'h32) begin errors++; $display("FAIL rmid_start: got start=%b data=%h expected 1 32", tx_start, tx_data); end
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    vectors++; if (tx_start !== 1'b0 || fifo_rd_en !== 1'b0) begin errors++; $display("FAIL rmid_async_ctl: got start=%b rd=%b expected 0 0", tx_start, fifo_rd_en); end
    vectors++; if (tx_data !== 8'h00 || tx_count !== 16'h0000) begin errors++; $display("FAIL rmid_async_data: got data=%h count=%h expected 00 0000", tx_data, tx_count); end
    vectors++; if (active !== 1'b0) begin errors++; $display("FAIL rmid_async_idle: got %b expected 0", active); end
    @(negedge clk);
    reset = 1'b0; ack_delay = 0;
    wait_idle(100, ok);
    vectors++; if (!ok) begin errors++; $display("FAIL rmid_timeout: got busy expected idle"); end
    vectors++; if (sent_q.size() != 1 || sent_q[0] !== 8'h33) begin errors++; $display("FAIL rmid_next: got %0d bytes expected 1 byte 33", sent_q.size()); end
    vectors++; if (tx_count !== 16'd1 || rd_pulses != 2) begin errors++; $display("FAIL rmid_counts: got count=%0d rd=%0d expected 1 2", tx_count, rd_pulses); end
  endtask

  task automatic test_wrap();
    bit ok;
    do_reset();
    enable = 1'b1; ack_delay = 0; busy_len = 2;
    @(negedge clk);
    for (int i = 0; i < 15; i++) fifo_q.push_back(8'h40 + 8'(i));
    wait_idle(1000, ok);
    vectors++; if (!ok) begin errors++; $display("FAIL wrap_timeout1: got busy expected idle"); end
    vectors++; if (n_count !== 4'hF || tx_count !== 16'd15) begin errors++; $display("FAIL wrap_allones: got n=%h main=%0d expected f 15", n_count, tx_count); end
    @(negedge clk);
    fifo_q.push_back(8'h7E);
    wait_idle(100, ok);
    vectors++; if (!ok) begin errors++; $display("FAIL wrap_timeout2: got busy expected idle"); end
    vectors++; if (n_count !== 4'h0) begin errors++; $display("FAIL wrap_zero: got %h expected 0", n_count); end
    vectors++; if (tx_count !== 16'd16 || sent_q.size() != 16) begin errors++; $display("FAIL wrap_main: got count=%0d sent=%0d expected 16 16", tx_count, sent_q.size()); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_flush();
    test_enable_drop();
    test_reset_mid();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
